// File: rtl/branch_predictor_bht.sv
// Branch predictor: direct-mapped history table of saturating counters plus a tagged BTB.
// Optional gshare indexing; lookup is combinational and updates are registered.
module branch_predictor_bht #(
   parameter int PC_W    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int MODE    = 1,
   parameter int GHR_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  pred_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_valid,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_mispredict,
   output logic [15:0]      branch_cnt,
   output logic [15:0]      mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1 << (CNT_W - 1));

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [PC_W-1:0]  tgt_q   [ENTRIES];
   logic [CNT_W-1:0] cnt_q   [ENTRIES];

   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [15:0]      branch_cnt_q, branch_cnt_d;
   logic [15:0]      mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0] look_idx, upd_idx;
   logic [TAG_W-1:0] look_tag, upd_tag;
   logic             look_match, upd_match;

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic up);
      if (up)
         return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
      else
         return (c == '0) ? c : c - CNT_W'(1);
   endfunction

   function automatic logic [15:0] stat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // gshare folds the history into the low index bits; other modes use the PC alone
   always_comb begin
      look_idx = pred_pc[IDX_W+1:2];
      upd_idx  = upd_pc[IDX_W+1:2];
      if (MODE == 2) begin
         look_idx = look_idx ^ IDX_W'(ghr_q);
         upd_idx  = upd_idx ^ IDX_W'(upd_ghr);
      end
   end

   assign look_tag   = pred_pc[PC_W-1:IDX_W+2];
   assign upd_tag    = upd_pc[PC_W-1:IDX_W+2];
   assign look_match = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
   assign upd_match  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   assign pred_hit    = pred_valid && look_match;
   assign pred_taken  = (MODE != 0) && pred_hit && cnt_q[look_idx][CNT_W-1];
   assign pred_target = pred_hit ? tgt_q[look_idx] : '0;
   assign pred_ghr    = ghr_q;

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

   always_comb begin
      ghr_d            = ghr_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (upd_valid) begin
         ghr_d        = (MODE == 2) ? ((ghr_q << 1) | GHR_W'(upd_taken)) : '0;
         branch_cnt_d = stat_inc(branch_cnt_q);
         if (upd_mispredict)
            mispredict_cnt_d = stat_inc(mispredict_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= CNT_RST;
         end
         ghr_q            <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (upd_valid) begin
            if (upd_match) begin
               cnt_q[upd_idx] <= cnt_step(cnt_q[upd_idx], upd_taken);
               if (upd_taken)
                  tgt_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
               // A taken miss evicts whatever aliases into this slot
               valid_q[upd_idx] <= 1'b1;
               tag_q[upd_idx]   <= upd_tag;
               tgt_q[upd_idx]   <= upd_target;
               cnt_q[upd_idx]   <= CNT_ALLOC;
            end
         end
         ghr_q            <= ghr_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0], upd_ghr};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: per-PC predictor instance (a_*) and gshare instance (b_*).
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_pred_valid = 0, a_upd_valid = 0, a_upd_taken = 0, a_upd_mispredict = 0;
   logic [31:0] a_pred_pc = 0, a_upd_pc = 0, a_upd_target = 0, a_pred_target;
   logic [3:0]  a_upd_ghr = 0, a_pred_ghr;
   logic        a_pred_hit, a_pred_taken;
   logic [15:0] a_branch_cnt, a_mispredict_cnt;

   logic        b_pred_valid = 0, b_upd_valid = 0, b_upd_taken = 0, b_upd_mispredict = 0;
   logic [31:0] b_pred_pc = 0, b_upd_pc = 0, b_upd_target = 0, b_pred_target;
   logic [3:0]  b_upd_ghr = 0, b_pred_ghr;
   logic        b_pred_hit, b_pred_taken;
   logic [15:0] b_branch_cnt, b_mispredict_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_predictor_bht #(.PC_W(32), .ENTRIES(16), .CNT_W(2), .MODE(1), .GHR_W(4)) u_a (
      .clk(clk), .rst(rst),
      .pred_valid(a_pred_valid), .pred_pc(a_pred_pc), .pred_hit(a_pred_hit),
      .pred_taken(a_pred_taken), .pred_target(a_pred_target), .pred_ghr(a_pred_ghr),
      .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_taken(a_upd_taken),
      .upd_target(a_upd_target), .upd_ghr(a_upd_ghr), .upd_mispredict(a_upd_mispredict),
      .branch_cnt(a_branch_cnt), .mispredict_cnt(a_mispredict_cnt)
   );

   branch_predictor_bht #(.PC_W(32), .ENTRIES(16), .CNT_W(2), .MODE(2), .GHR_W(4)) u_b (
      .clk(clk), .rst(rst),
      .pred_valid(b_pred_valid), .pred_pc(b_pred_pc), .pred_hit(b_pred_hit),
      .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_ghr(b_pred_ghr),
      .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
      .upd_target(b_upd_target), .upd_ghr(b_upd_ghr), .upd_mispredict(b_upd_mispredict),
      .branch_cnt(b_branch_cnt), .mispredict_cnt(b_mispredict_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
   endtask

   task automatic look_a(input logic [31:0] pc);
      a_pred_valid = 1'b1;
      a_pred_pc    = pc;
      #1;
   endtask

   task automatic upd_a(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
      a_upd_valid = 1'b1; a_upd_pc = pc; a_upd_taken = tk; a_upd_target = tgt; a_upd_mispredict = mis;
      @(posedge clk); #1;
      a_upd_valid = 1'b0; a_upd_mispredict = 1'b0;
   endtask

   task automatic upd_b(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic [3:0] ghr);
      b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_taken = tk; b_upd_target = tgt; b_upd_ghr = ghr;
      @(posedge clk); #1;
      b_upd_valid = 1'b0;
   endtask

   initial begin
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // Reset state and cold lookup
      look_a(32'h40);
      chk("rst_hit",    32'(a_pred_hit),      32'd0);
      chk("rst_taken",  32'(a_pred_taken),    32'd0);
      chk("rst_target", a_pred_target,        32'd0);
      chk("rst_ghr",    32'(a_pred_ghr),      32'd0);
      chk("rst_bcnt",   32'(a_branch_cnt),    32'd0);
      chk("rst_mcnt",   32'(a_mispredict_cnt), 32'd0);

      // Allocate on taken miss: weakly taken
      upd_a(32'h40, 1'b1, 32'h80, 1'b1);
      look_a(32'h40);
      chk("alloc_hit",    32'(a_pred_hit),   32'd1);
      chk("alloc_taken",  32'(a_pred_taken), 32'd1);
      chk("alloc_target", a_pred_target,     32'h80);
      chk("alloc_bcnt",   32'(a_branch_cnt), 32'd1);
      chk("alloc_mcnt",   32'(a_mispredict_cnt), 32'd1);

      // Not-taken hits decrement, saturate at 0, keep target
      upd_a(32'h40, 1'b0, 32'h123, 1'b0);
      look_a(32'h40);
      chk("nt1_taken",  32'(a_pred_taken), 32'd0);
      chk("nt1_target", a_pred_target,     32'h80);
      upd_a(32'h40, 1'b0, 32'h0, 1'b0);
      upd_a(32'h40, 1'b0, 32'h0, 1'b0);
      look_a(32'h40);
      chk("nt3_taken", 32'(a_pred_taken), 32'd0);
      chk("nt3_hit",   32'(a_pred_hit),   32'd1);
      upd_a(32'h40, 1'b1, 32'h84, 1'b0);
      look_a(32'h40);
      chk("t_after_sat_taken",  32'(a_pred_taken), 32'd0);
      chk("t_after_sat_target", a_pred_target,     32'h84);
      chk("t_after_sat_bcnt",   32'(a_branch_cnt), 32'd5);

      // Not-taken miss leaves the table alone
      upd_a(32'h48, 1'b0, 32'h999, 1'b0);
      look_a(32'h48);
      chk("ntmiss_hit", 32'(a_pred_hit), 32'd0);

      // Alias at index 0 with a different tag
      look_a(32'h440);
      chk("alias_pre_hit",    32'(a_pred_hit), 32'd0);
      chk("alias_pre_target", a_pred_target,   32'd0);
      upd_a(32'h440, 1'b1, 32'h200, 1'b1);
      look_a(32'h440);
      chk("alias_hit",    32'(a_pred_hit),   32'd1);
      chk("alias_taken",  32'(a_pred_taken), 32'd1);
      chk("alias_target", a_pred_target,     32'h200);
      look_a(32'h40);
      chk("evicted_hit",    32'(a_pred_hit), 32'd0);
      chk("evicted_target", a_pred_target,   32'd0);

      // Upper saturation: 2 -> 3 -> 3, then one not-taken leaves it taken
      upd_a(32'h440, 1'b1, 32'h200, 1'b0);
      upd_a(32'h440, 1'b1, 32'h200, 1'b0);
      upd_a(32'h440, 1'b0, 32'h0, 1'b0);
      look_a(32'h440);
      chk("topsat_taken", 32'(a_pred_taken), 32'd1);

      // Same-cycle lookup and update: no bypass
      a_pred_valid = 1'b1; a_pred_pc = 32'h40;
      a_upd_valid = 1'b1; a_upd_pc = 32'h40; a_upd_taken = 1'b1; a_upd_target = 32'h300; a_upd_mispredict = 1'b1;
      #1;
      chk("same_cycle_hit", 32'(a_pred_hit), 32'd0);
      @(posedge clk); #1;
      a_upd_valid = 1'b0; a_upd_mispredict = 1'b0;
      chk("next_cycle_hit",    32'(a_pred_hit),   32'd1);
      chk("next_cycle_target", a_pred_target,     32'h300);
      chk("pre_rst_bcnt",      32'(a_branch_cnt), 32'd11);
      chk("pre_rst_mcnt",      32'(a_mispredict_cnt), 32'd3);

      // Asynchronous reset mid-stream
      #2 rst = 1'b1;
      #1;
      chk("async_rst_hit",    32'(a_pred_hit),      32'd0);
      chk("async_rst_taken",  32'(a_pred_taken),    32'd0);
      chk("async_rst_target", a_pred_target,        32'd0);
      chk("async_rst_bcnt",   32'(a_branch_cnt),    32'd0);
      chk("async_rst_mcnt",   32'(a_mispredict_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      look_a(32'h40);
      chk("post_rst_hit", 32'(a_pred_hit), 32'd0);

      // gshare history and indexing
      b_pred_valid = 1'b1; b_pred_pc = 32'h40;
      upd_b(32'h40, 1'b1, 32'h500, 4'h0);
      chk("ghr_1", 32'(b_pred_ghr), 32'h1);
      upd_b(32'h40, 1'b1, 32'h500, 4'h1);
      chk("ghr_3", 32'(b_pred_ghr), 32'h3);
      upd_b(32'h40, 1'b1, 32'h500, 4'h3);
      chk("ghr_7", 32'(b_pred_ghr), 32'h7);
      upd_b(32'h40, 1'b1, 32'h500, 4'h7);
      chk("ghr_f", 32'(b_pred_ghr), 32'hF);
      chk("gs_idx15_miss", 32'(b_pred_hit), 32'd0);
      upd_b(32'h40, 1'b1, 32'h600, 4'hF);
      chk("gs_idx15_hit",    32'(b_pred_hit),    32'd1);
      chk("gs_idx15_taken",  32'(b_pred_taken),  32'd1);
      chk("gs_idx15_target", b_pred_target,      32'h600);

      // Statistics saturate rather than wrap
      b_upd_valid = 1'b1; b_upd_pc = 32'h40; b_upd_taken = 1'b1; b_upd_target = 32'h600;
      b_upd_ghr = 4'hF; b_upd_mispredict = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      b_upd_valid = 1'b0; b_upd_mispredict = 1'b0;
      chk("bcnt_sat", 32'(b_branch_cnt),     32'hFFFF);
      chk("mcnt_sat", 32'(b_mispredict_cnt), 32'hFFFF);
      chk("ghr_hold", 32'(b_pred_ghr),       32'hF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
